// File: rtl/pixel_frame_writer.sv
// Streams one raster frame from an upstream filter into a frame buffer, one write per accepted pixel.
// Optional per-frame statistics (frame_max, frame_sum) are enabled by defining PIXEL_FRAME_WRITER_STATS_EN.
module pixel_frame_writer #(
   parameter int BITS   = 8,
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [BITS-1:0]   pix_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BITS-1:0]   mem_data,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       x_pos,
   output logic [15:0]       y_pos
`ifdef PIXEL_FRAME_WRITER_STATS_EN
   ,
   output logic [BITS-1:0]        frame_max,
   output logic [BITS+ADDR_W-1:0] frame_sum
`endif
);

   localparam int NPIX = WIDTH * HEIGHT;

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_cnt;
   logic              transfer;
   logic              accept;
   logic              last_pix;
   logic              arm;

   assign ready_out = (state_q == CAPTURE) && (!mem_we || mem_ready);
   assign transfer  = valid_in && ready_out;
   assign accept    = mem_we && mem_ready;
   assign last_pix  = (addr_cnt == ADDR_W'(NPIX - 1));
   assign arm       = (state_q == IDLE) && start;
   assign busy      = (state_q != IDLE);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      frame_done = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = CAPTURE;
         CAPTURE: if (transfer && last_pix) state_d = DRAIN;
         DRAIN: begin
            if (accept) begin
               frame_done = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         addr_cnt <= '0;
         x_pos    <= '0;
         y_pos    <= '0;
      end else begin
         if (arm) begin
            addr_cnt <= '0;
            x_pos    <= '0;
            y_pos    <= '0;
         end
         // A new transfer re-arms the write in the same cycle the previous one is accepted.
         if (transfer) begin
            mem_we   <= 1'b1;
            mem_data <= pix_in;
            mem_addr <= addr_cnt;
            addr_cnt <= addr_cnt + 1'b1;
            if (x_pos == 16'(WIDTH - 1)) begin
               x_pos <= '0;
               y_pos <= y_pos + 16'd1;
            end else begin
               x_pos <= x_pos + 16'd1;
            end
         end else if (accept) begin
            mem_we <= 1'b0;
         end
      end
   end

`ifdef PIXEL_FRAME_WRITER_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_max <= '0;
         frame_sum <= '0;
      end else if (arm) begin
         frame_max <= '0;
         frame_sum <= '0;
      end else if (transfer) begin
         if (pix_in > frame_max) frame_max <= pix_in;
         frame_sum <= frame_sum + (BITS + ADDR_W)'(pix_in);
      end
   end
`endif

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed self-checking bench for pixel_frame_writer on a 4x2 frame.
// Define PIXEL_FRAME_WRITER_STATS_EN to also check the statistics outputs.
module tb_pixel_frame_writer;

   localparam int BITS   = 8;
   localparam int WIDTH  = 4;
   localparam int HEIGHT = 2;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [BITS-1:0]   pix_in = '0;
   logic              valid_in = 1'b0;
   logic              mem_ready = 1'b1;
   logic              ready_out;
   logic [ADDR_W-1:0] mem_addr;
   logic [BITS-1:0]   mem_data;
   logic              mem_we;
   logic              busy;
   logic              frame_done;
   logic [15:0]       x_pos;
   logic [15:0]       y_pos;
`ifdef PIXEL_FRAME_WRITER_STATS_EN
   logic [BITS-1:0]        frame_max;
   logic [BITS+ADDR_W-1:0] frame_sum;
`endif

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [BITS-1:0]   data;
   } wr_t;

   int  checks   = 0;
   int  failures = 0;
   int  fd_count = 0;
   int  fd0;
   wr_t wlog[$];
   logic [BITS-1:0] stats_px [8] = '{8'd10, 8'd200, 8'd7, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0};

   pixel_frame_writer #(
      .BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .pix_in(pix_in), .valid_in(valid_in),
      .ready_out(ready_out), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
      .mem_ready(mem_ready), .busy(busy), .frame_done(frame_done), .x_pos(x_pos), .y_pos(y_pos)
`ifdef PIXEL_FRAME_WRITER_STATS_EN
      , .frame_max(frame_max), .frame_sum(frame_sum)
`endif
   );

   always #5 clk = ~clk;

   // Log accepted writes and frame_done pulses mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (frame_done) fd_count++;
      if (mem_we && mem_ready) wlog.push_back('{mem_addr, mem_data});
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 32'(ready_out), 0);
      check({tag, "_we"},    32'(mem_we), 0);
      check({tag, "_addr"},  32'(mem_addr), 0);
      check({tag, "_data"},  32'(mem_data), 0);
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_done"},  32'(frame_done), 0);
      check({tag, "_x"},     32'(x_pos), 0);
      check({tag, "_y"},     32'(y_pos), 0);
`ifdef PIXEL_FRAME_WRITER_STATS_EN
      check({tag, "_max"},   32'(frame_max), 0);
      check({tag, "_sum"},   32'(frame_sum), 0);
`endif
   endtask

   initial begin
      // Reset with valid_in already high upstream.
      valid_in = 1'b1;
      pix_in   = 8'hAA;
      #1;
      check_all_zero("rst");
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("idle_ready", 32'(ready_out), 0);
         check("idle_we", 32'(mem_we), 0);
      end

      // Frame 1: everything held high, pixels 0x10..0x17.
      wlog.delete();
      fd0   = fd_count;
      start = 1'b1;
      step();
      start  = 1'b0;
      pix_in = 8'h10;
      #1;
      check("f1_ready", 32'(ready_out), 1);
      check("f1_busy", 32'(busy), 1);
      check("f1_we0", 32'(mem_we), 0);
      for (int i = 0; i < 8; i++) begin
         step();
         check("f1_we", 32'(mem_we), 1);
         check("f1_addr", 32'(mem_addr), 32'(i));
         check("f1_data", 32'(mem_data), 32'(8'h10 + i));
         if (i == 4) begin
            check("f1_x5", 32'(x_pos), 1);
            check("f1_y5", 32'(y_pos), 1);
         end
         pix_in = 8'(8'h11 + i);
         if (i == 7) begin
            start = 1'b1;
            #1;
            check("f1_done_last", 32'(frame_done), 1);
            check("f1_drain_busy", 32'(busy), 1);
            check("f1_drain_ready", 32'(ready_out), 0);
         end else begin
            #1;
            check("f1_done_early", 32'(frame_done), 0);
         end
      end
      step();
      start = 1'b0;
      check("f1_end_busy", 32'(busy), 0);
      check("f1_end_we", 32'(mem_we), 0);
      check("f1_end_done", 32'(frame_done), 0);
      check("f1_end_ready", 32'(ready_out), 0);
      step();
      check("f1_start_at_done_ignored", 32'(busy), 0);
      check("f1_done_count", 32'(fd_count - fd0), 1);
      check("f1_log_size", 32'(wlog.size()), 8);
      for (int i = 0; i < 8 && i < wlog.size(); i++) begin
         check("f1_log_addr", 32'(wlog[i].addr), 32'(i));
         check("f1_log_data", 32'(wlog[i].data), 32'(8'h10 + i));
      end

      // Frame 2: memory stalls for 3 cycles while pixel 2 is pending; start mid-frame ignored.
      wlog.delete();
      fd0   = fd_count;
      start = 1'b1;
      step();
      start  = 1'b0;
      pix_in = 8'h40;
      for (int k = 0; k < 3; k++) begin
         step();
         pix_in = 8'(8'h41 + k);
      end
      for (int c = 0; c < 3; c++) begin
         if (c > 0) step();
         mem_ready = 1'b0;
         start     = (c == 1);
         #1;
         check("f2_stall_we", 32'(mem_we), 1);
         check("f2_stall_addr", 32'(mem_addr), 2);
         check("f2_stall_data", 32'(mem_data), 32'h42);
         check("f2_stall_ready", 32'(ready_out), 0);
         check("f2_stall_x", 32'(x_pos), 3);
      end
      start     = 1'b0;
      mem_ready = 1'b1;
      #1;
      check("f2_resume_ready", 32'(ready_out), 1);
      for (int k = 3; k < 8; k++) begin
         step();
         check("f2_addr", 32'(mem_addr), 32'(k));
         check("f2_data", 32'(mem_data), 32'(8'h40 + k));
         pix_in = 8'(8'h41 + k);
      end
      step();
      check("f2_end_busy", 32'(busy), 0);
      check("f2_done_count", 32'(fd_count - fd0), 1);
      check("f2_log_size", 32'(wlog.size()), 8);
      for (int i = 0; i < 8 && i < wlog.size(); i++) begin
         check("f2_log_addr", 32'(wlog[i].addr), 32'(i));
         check("f2_log_data", 32'(wlog[i].data), 32'(8'h40 + i));
      end

      // Frame 3: reset after pixel 3 is transferred.
      start = 1'b1;
      step();
      start  = 1'b0;
      pix_in = 8'h60;
      for (int k = 0; k < 4; k++) begin
         step();
         pix_in = 8'(8'h61 + k);
      end
      check("f3_pending_addr", 32'(mem_addr), 3);
      fd0   = fd_count;
      reset = 1'b0;
      #1;
      check_all_zero("midrst");
      step();
      reset = 1'b1;
      #1;
      check("f3_post_ready", 32'(ready_out), 0);
      step();
      check("f3_no_restart", 32'(busy), 0);
      check("f3_no_we", 32'(mem_we), 0);
      check("f3_no_done", 32'(fd_count - fd0), 0);

      // Frame 4: restart at address 0 with the statistics pixel set.
      wlog.delete();
      fd0   = fd_count;
      start = 1'b1;
      step();
      start  = 1'b0;
      pix_in = stats_px[0];
      for (int k = 0; k < 8; k++) begin
         step();
         check("f4_addr", 32'(mem_addr), 32'(k));
         check("f4_data", 32'(mem_data), 32'(stats_px[k]));
         if (k < 7) pix_in = stats_px[k + 1];
      end
      check("f4_done", 32'(frame_done), 1);
`ifdef PIXEL_FRAME_WRITER_STATS_EN
      check("f4_max", 32'(frame_max), 200);
      check("f4_sum", 32'(frame_sum), 267);
`endif
      pix_in = 8'hFF;
      step();
      step();
      check("f4_end_busy", 32'(busy), 0);
      check("f4_done_count", 32'(fd_count - fd0), 1);
`ifdef PIXEL_FRAME_WRITER_STATS_EN
      check("f4_max_hold", 32'(frame_max), 200);
      check("f4_sum_hold", 32'(frame_sum), 267);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
